// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and default parameter values.
package cpu_pkg;

  localparam int unsigned IwDefault      = 16;
  localparam int unsigned AwDefault      = 8;
  localparam int unsigned ResetPcDefault = 0;
  localparam int unsigned SkipRegDefault = 0;
  localparam int unsigned CwDefault      = 16;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StReg = 3'd2,
    StEx  = 3'd3,
    StWb  = 3'd4,
    StHlt = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Fetch bus and decoder handshake between the sequencer and its environment.
interface cpu_seq_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned IW = IwDefault,
  parameter int unsigned AW = AwDefault
);

  logic          IMEM_REQ;
  logic [AW-1:0] IMEM_ADDR;
  logic          IMEM_ACK;
  logic [IW-1:0] IMEM_DATA;
  logic [IW-1:0] INST;
  logic          DEC_OIN;
  logic          HALT_INST;
  logic          BR_TAKE;
  logic [AW-1:0] BR_TGT;
  logic          REG_OIN;

  modport master (
    output IMEM_REQ, IMEM_ADDR, INST, REG_OIN,
    input  IMEM_ACK, IMEM_DATA, DEC_OIN, HALT_INST, BR_TAKE, BR_TGT
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INST, REG_OIN,
    output IMEM_ACK, IMEM_DATA, DEC_OIN, HALT_INST, BR_TAKE, BR_TGT
  );

endinterface

// File: rtl/cpu_pc_unit.sv
// Program counter and saturating retired-instruction counter, both updated on retire.
module cpu_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = AwDefault,
  parameter int unsigned CW       = CwDefault,
  parameter int unsigned RESET_PC = ResetPcDefault
) (
  input  logic          ck,
  input  logic          res,
  input  logic          advance,
  input  logic          br_take,
  input  logic [AW-1:0] br_tgt,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] ret_cnt
);

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (advance) begin
      // Sequential PC wraps naturally at 2^AW.
      pc_d = br_take ? br_tgt : pc_q + AW'(1);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      pc_q  <= AW'(RESET_PC);
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc      = pc_q;
  assign ret_cnt = cnt_q;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: IF -> ID -> (REG) -> EX -> WB, with terminal halt.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned IW       = IwDefault,
  parameter int unsigned AW       = AwDefault,
  parameter int unsigned RESET_PC = ResetPcDefault,
  parameter int unsigned SKIP_REG = SkipRegDefault,
  parameter int unsigned CW       = CwDefault
) (
  input  logic                 ck,
  input  logic                 res,
  input  logic                 RUN,
  cpu_seq_ctrl_if.master       bus,
  output logic [2:0]           STATE,
  output logic [AW-1:0]        PC,
  output logic                 RETIRE,
  output logic [CW-1:0]        RET_CNT,
  output logic                 HALTED
);

  seq_state_e    state_q;
  logic          pending_q;
  logic [IW-1:0] inst_q;
  logic          fetch_req;
  logic          in_wb;

  // A pending fetch keeps the request up even after RUN drops.
  assign fetch_req = (state_q == StIf) && (RUN || pending_q) && !res;
  assign in_wb     = (state_q == StWb);

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      state_q   <= StIf;
      pending_q <= 1'b0;
      inst_q    <= '0;
    end else begin
      case (state_q)
        StIf: begin
          if (fetch_req) begin
            if (bus.IMEM_ACK) begin
              inst_q    <= bus.IMEM_DATA;
              pending_q <= 1'b0;
              state_q   <= StId;
            end else begin
              pending_q <= 1'b1;
            end
          end
        end
        StId:    state_q <= (SKIP_REG != 0) ? StEx : StReg;
        StReg:   state_q <= StEx;
        StEx:    state_q <= StWb;
        StWb:    state_q <= bus.HALT_INST ? StHlt : StIf;
        StHlt:   state_q <= StHlt;
        default: state_q <= StIf;
      endcase
    end
  end

  cpu_pc_unit #(
    .AW       (AW),
    .CW       (CW),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .ck      (ck),
    .res     (res),
    .advance (in_wb),
    .br_take (bus.BR_TAKE),
    .br_tgt  (bus.BR_TGT),
    .pc      (PC),
    .ret_cnt (RET_CNT)
  );

  assign bus.IMEM_REQ  = fetch_req;
  assign bus.IMEM_ADDR = PC;
  assign bus.INST      = inst_q;
  assign bus.REG_OIN   = in_wb && bus.DEC_OIN;
  assign STATE         = state_q;
  assign RETIRE        = in_wb;
  assign HALTED        = (state_q == StHlt);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: a 5-state and a 4-state instance against a phase-count model.
module tb_cpu_seq_ctrl;

  localparam int IW = 16;
  localparam int AW = 8;

  logic ck  = 1'b0;
  logic res = 1'b1;
  always #5 ck = ~ck;

  logic          run  [2];
  logic          ack  [2];
  logic [IW-1:0] data [2];
  logic          dec  [2];
  logic          halt [2];
  logic          brt  [2];
  logic [AW-1:0] tgt  [2];

  logic [2:0]    st_o   [2];
  logic [AW-1:0] pc_o   [2];
  logic          ret_o  [2];
  logic          hlt_o  [2];
  logic          req_o  [2];
  logic [AW-1:0] addr_o [2];
  logic [IW-1:0] inst_o [2];
  logic          roin_o [2];
  logic [15:0]   cnt_o  [2];
  logic [15:0]   cnt0;
  logic [3:0]    cnt1;

  cpu_seq_ctrl_if #(.IW(IW), .AW(AW)) bus0 ();
  cpu_seq_ctrl_if #(.IW(IW), .AW(AW)) bus1 ();

  assign bus0.IMEM_ACK  = ack[0];
  assign bus0.IMEM_DATA = data[0];
  assign bus0.DEC_OIN   = dec[0];
  assign bus0.HALT_INST = halt[0];
  assign bus0.BR_TAKE   = brt[0];
  assign bus0.BR_TGT    = tgt[0];
  assign bus1.IMEM_ACK  = ack[1];
  assign bus1.IMEM_DATA = data[1];
  assign bus1.DEC_OIN   = dec[1];
  assign bus1.HALT_INST = halt[1];
  assign bus1.BR_TAKE   = brt[1];
  assign bus1.BR_TGT    = tgt[1];

  assign req_o[0]  = bus0.IMEM_REQ;
  assign addr_o[0] = bus0.IMEM_ADDR;
  assign inst_o[0] = bus0.INST;
  assign roin_o[0] = bus0.REG_OIN;
  assign req_o[1]  = bus1.IMEM_REQ;
  assign addr_o[1] = bus1.IMEM_ADDR;
  assign inst_o[1] = bus1.INST;
  assign roin_o[1] = bus1.REG_OIN;
  assign cnt_o[0]  = cnt0;
  assign cnt_o[1]  = {12'd0, cnt1};

  cpu_seq_ctrl #(
    .IW(IW), .AW(AW), .RESET_PC(0), .SKIP_REG(0), .CW(16)
  ) dut0 (
    .ck(ck), .res(res), .RUN(run[0]), .bus(bus0.master), .STATE(st_o[0]), .PC(pc_o[0]),
    .RETIRE(ret_o[0]), .RET_CNT(cnt0), .HALTED(hlt_o[0])
  );

  cpu_seq_ctrl #(
    .IW(IW), .AW(AW), .RESET_PC(0), .SKIP_REG(1), .CW(4)
  ) dut1 (
    .ck(ck), .res(res), .RUN(run[1]), .bus(bus1.master), .STATE(st_o[1]), .PC(pc_o[1]),
    .RETIRE(ret_o[1]), .RET_CNT(cnt1), .HALTED(hlt_o[1])
  );

  // Model: phase = cycles since the fetch was accepted (0 while in IF).
  int            m_phase  [2];
  bit            m_pend   [2];
  bit            m_halted [2];
  int unsigned   m_pc     [2];
  int unsigned   m_cnt    [2];
  logic [IW-1:0] m_inst   [2];
  int unsigned   cnt_max  [2] = '{65535, 15};
  bit            skip     [2] = '{1'b0, 1'b1};

  int seq0 [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
  int seq1 [10] = '{0, 1, 3, 4, 0, 1, 3, 4, 0, 1};
  int pcs0 [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int pcs1 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};

  int checks = 0;
  int errors = 0;

  function automatic int exp_state(int d);
    if (m_halted[d]) return 5;
    if (m_phase[d] == 0) return 0;
    if (skip[d] && m_phase[d] >= 2) return m_phase[d] + 1;
    return m_phase[d];
  endfunction

  function automatic bit exp_req(int d);
    return (exp_state(d) == 0) && (run[d] || m_pend[d]);
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_pend[d] = 0; m_halted[d] = 0;
      m_pc[d] = 0; m_cnt[d] = 0; m_inst[d] = '0;
    end
  endtask

  task automatic compare(input int d);
    int s;
    s = exp_state(d);
    check("state", d, 32'(st_o[d]), 32'(s));
    check("imem_req", d, 32'(req_o[d]), 32'(exp_req(d)));
    check("imem_addr", d, 32'(addr_o[d]), m_pc[d]);
    check("pc", d, 32'(pc_o[d]), m_pc[d]);
    check("inst", d, 32'(inst_o[d]), 32'(m_inst[d]));
    check("reg_oin", d, 32'(roin_o[d]), 32'(s == 4 && dec[d]));
    check("retire", d, 32'(ret_o[d]), 32'(s == 4));
    check("halted", d, 32'(hlt_o[d]), 32'(s == 5));
    check("ret_cnt", d, 32'(cnt_o[d]), m_cnt[d]);
  endtask

  task automatic advance(input int d);
    int s;
    s = exp_state(d);
    if (s == 0) begin
      if (exp_req(d)) begin
        if (ack[d]) begin
          m_inst[d] = data[d]; m_pend[d] = 0; m_phase[d] = 1;
        end else begin
          m_pend[d] = 1;
        end
      end
    end else if (s == 4) begin
      if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
      if (brt[d]) m_pc[d] = 32'(tgt[d]);
      else m_pc[d] = (m_pc[d] + 1) % 256;
      if (halt[d]) m_halted[d] = 1;
      else m_phase[d] = 0;
    end else if (s != 5) begin
      m_phase[d]++;
    end
  endtask

  // Called 1 time unit after the negedge, inputs already applied.
  task automatic tick();
    compare(0);
    compare(1);
    advance(0);
    advance(1);
    @(negedge ck);
  endtask

  task automatic idle_inputs(input int d);
    run[d] = 0; ack[d] = 0; data[d] = '0; dec[d] = 0;
    halt[d] = 0; brt[d] = 0; tgt[d] = '0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_state", d, 32'(st_o[d]), 0);
      check("rst_pc", d, 32'(pc_o[d]), 0);
      check("rst_cnt", d, 32'(cnt_o[d]), 0);
      check("rst_req", d, 32'(req_o[d]), 0);
      check("rst_retire", d, 32'(ret_o[d]), 0);
      check("rst_halted", d, 32'(hlt_o[d]), 0);
      check("rst_reg_oin", d, 32'(roin_o[d]), 0);
      check("rst_inst", d, 32'(inst_o[d]), 0);
    end
    model_reset();
    @(negedge ck);
    res = 1'b0;
  endtask

  task automatic run_instr(input int d, input bit br, input logic [AW-1:0] t, input bit h);
    bit seen_wb;
    seen_wb = 0;
    for (int n = 0; n < 40 && !seen_wb; n++) begin
      run[d] = 1; ack[d] = 1; data[d] = IW'($urandom); dec[d] = 1'($urandom);
      brt[d] = br; tgt[d] = t; halt[d] = h;
      #1;
      if (exp_state(d) == 4) seen_wb = 1;
      tick();
    end
    if (!seen_wb) begin
      checks++; errors++;
      $display("FAIL run_instr dut%0d: no write-back within 40 cycles", d);
    end
    idle_inputs(d);
  endtask

  initial begin
    bit reached;
    for (int d = 0; d < 2; d++) idle_inputs(d);
    @(negedge ck);
    do_reset();

    // Zero-wait fetch, continuous run: pinned state and PC sequences.
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        run[d] = 1; ack[d] = 1; dec[d] = 1; data[d] = 16'h1000 + 16'(i);
      end
      #1;
      check("seq_state", 0, 32'(st_o[0]), 32'(seq0[i]));
      check("seq_state", 1, 32'(st_o[1]), 32'(seq1[i]));
      check("seq_pc", 0, 32'(pc_o[0]), 32'(pcs0[i]));
      check("seq_pc", 1, 32'(pc_o[1]), 32'(pcs1[i]));
      check("seq_reg_oin", 0, 32'(roin_o[0]), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      tick();
    end
    for (int d = 0; d < 2; d++) idle_inputs(d);
    #1;
    check("seq_pc2", 0, 32'(pc_o[0]), 2);
    for (int i = 0; i < 6; i++) tick();

    // Delayed ACK with RUN dropped after the first cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        run[d] = (i == 0); ack[d] = (i == 3); data[d] = 16'hBEEF;
      end
      #1;
      check("held_req", 0, 32'(req_o[0]), 1);
      check("held_req", 1, 32'(req_o[1]), 1);
      tick();
    end
    for (int d = 0; d < 2; d++) idle_inputs(d);
    #1;
    check("ack_inst", 0, 32'(inst_o[0]), 32'h0000BEEF);
    check("ack_inst", 1, 32'(inst_o[1]), 32'h0000BEEF);
    check("ack_state", 0, 32'(st_o[0]), 1);
    for (int i = 0; i < 8; i++) tick();

    // PC wrap and branch target.
    do_reset();
    run_instr(0, 1'b1, 8'hFF, 1'b0);
    #1;
    check("br_pc", 0, 32'(pc_o[0]), 255);
    tick();
    run_instr(0, 1'b0, 8'h00, 1'b0);
    #1;
    check("wrap_pc", 0, 32'(pc_o[0]), 0);
    tick();
    run_instr(0, 1'b1, 8'h40, 1'b0);
    #1;
    check("tgt_pc", 0, 32'(pc_o[0]), 32'h40);
    tick();

    // Halt with a simultaneous branch; stays halted with requests held off.
    do_reset();
    run_instr(0, 1'b1, 8'h10, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run[0] = 1; ack[0] = 1;
      #1;
      check("hlt_state", 0, 32'(st_o[0]), 5);
      check("hlt_halted", 0, 32'(hlt_o[0]), 1);
      check("hlt_req", 0, 32'(req_o[0]), 0);
      tick();
    end
    check("hlt_cnt", 0, 32'(cnt_o[0]), 1);
    check("hlt_pc", 0, 32'(pc_o[0]), 32'h10);
    idle_inputs(0);

    // Reset asserted asynchronously while in EX.
    do_reset();
    reached = 0;
    for (int n = 0; n < 20 && !reached; n++) begin
      run[0] = 1; ack[0] = 1; dec[0] = 1;
      #1;
      if (exp_state(0) == 3) reached = 1;
      else tick();
    end
    if (!reached) begin
      checks++; errors++;
      $display("FAIL abort_reach dut0: EX not reached within 20 cycles");
    end
    res = 1'b1;
    #1;
    check("abort_state", 0, 32'(st_o[0]), 0);
    check("abort_pc", 0, 32'(pc_o[0]), 0);
    check("abort_retire", 0, 32'(ret_o[0]), 0);
    check("abort_cnt", 0, 32'(cnt_o[0]), 0);
    check("abort_req", 0, 32'(req_o[0]), 0);
    model_reset();
    @(negedge ck);
    res = 1'b0;
    idle_inputs(0);
    for (int i = 0; i < 6; i++) begin
      #1;
      tick();
    end

    // Four-state variant: counter saturation at CW=4.
    do_reset();
    for (int k = 0; k < 20; k++) run_instr(1, 1'b0, 8'h00, 1'b0);
    check("sat_cnt", 1, 32'(cnt_o[1]), 15);
    check("sat_pc", 1, 32'(pc_o[1]), 20);

    // Randomized traffic on both instances.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        run[d]  = ($urandom_range(0, 3) != 0);
        ack[d]  = ($urandom_range(0, 2) == 0);
        data[d] = IW'($urandom);
        dec[d]  = 1'($urandom);
        halt[d] = ($urandom_range(0, 29) == 0);
        brt[d]  = ($urandom_range(0, 3) == 0);
        tgt[d]  = ($urandom_range(0, 3) == 0) ? 8'hFF : AW'($urandom);
      end
      #1;
      tick();
      if ((m_halted[0] && m_halted[1]) || $urandom_range(0, 199) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
